control_mc: RTL and testbench

Parametrised multicycle control unit for the accumulator processor. It sequences the Fetch/Read/Execute states and adds a program-memory ready handshake, switch-selectable WAIT instructions with an optional timeout, a zero-flag branch and a HALT state. All datapath strobes are gated to the instruction's commit cycle. It drives the register file, ALU, accumulator and PC mux.

---
 rtl/control_mc.sv | 124 ++++++++++++
 tb/tb_control_mc.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_mc.sv
// Multicycle control unit: Fetch/Read/Execute sequencing with memory handshake, WAIT, BZ, JMPA and HALT.
// Latency: 3 cycles per non-WAIT instruction plus MemRdy stall cycles; datapath strobes only in the commit cycle.
module control_mc #(
  parameter int NUM_SW        = 8,
  parameter int WAIT_TIMEOUT  = 0,
  parameter int MEM_HANDSHAKE = 1,
  parameter int RET_W         = 16
) (
  input  logic                                         i_clock,
  input  logic                                         i_reset,
  input  logic [3:0]                                   i_opcode,
  input  logic [((NUM_SW > 1) ? $clog2(NUM_SW) : 1)-1:0] i_sw_idx,
  input  logic [NUM_SW-1:0]                            i_sw,
  input  logic                                         i_zero,
  input  logic                                         i_mem_rdy,
  output logic                                         o_mem_req,
  output logic                                         o_reg_we,
  output logic                                         o_wdata_sel,
  output logic                                         o_acc_store,
  output logic                                         o_op1_sel,
  output logic                                         o_imm_sel,
  output logic [1:0]                                   o_alu_op,
  output logic [1:0]                                   o_pc_sel,
  output logic [2:0]                                   o_state,
  output logic                                         o_timeout,
  output logic [RET_W-1:0]                             o_retired
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3
  } state_t;

  localparam logic [3:0] OP_HALT  = 4'b0011;
  localparam logic [3:0] OP_WAIT0 = 4'b0100;
  localparam logic [3:0] OP_WAIT1 = 4'b0101;
  localparam logic [3:0] OP_JMPA  = 4'b0110;
  localparam logic [3:0] OP_BZ    = 4'b0111;

  localparam logic [1:0] PC_WAIT = 2'd0;
  localparam logic [1:0] PC_INC  = 2'd1;
  localparam logic [1:0] PC_JMP  = 2'd2;

  localparam int             WCW      = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [WCW-1:0] TMO_LAST = WCW'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

  state_t           r_state;
  state_t           w_next;
  logic [WCW-1:0]   r_wait_cnt;
  logic [RET_W-1:0] r_retired;
  logic             w_commit;
  logic             w_wait_hold;
  logic             w_sel_sw;
  logic             w_wait_done;
  logic             w_tmo_hit;

  // Indices past the last switch read as 0 rather than wrapping.
  assign w_sel_sw    = (int'(i_sw_idx) < NUM_SW) ? i_sw[i_sw_idx] : 1'b0;
  assign w_wait_done = (i_opcode == OP_WAIT0) ? w_sel_sw : ~w_sel_sw;
  assign w_tmo_hit   = (WAIT_TIMEOUT != 0) && (r_wait_cnt == TMO_LAST);

  always_comb begin
    w_next      = S_FETCH;
    o_mem_req   = 1'b0;
    o_pc_sel    = PC_WAIT;
    o_timeout   = 1'b0;
    w_commit    = 1'b0;
    w_wait_hold = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_mem_req = 1'b1;
        w_next    = (MEM_HANDSHAKE == 0 || i_mem_rdy) ? S_READ : S_FETCH;
      end
      S_READ: w_next = S_EXEC;
      S_EXEC: begin
        w_commit = 1'b1;
        case (i_opcode)
          OP_WAIT0, OP_WAIT1: begin
            if (w_wait_done) begin
              o_pc_sel = PC_INC;
            end else if (w_tmo_hit) begin
              o_pc_sel  = PC_INC;
              o_timeout = 1'b1;
            end else begin
              w_commit    = 1'b0;
              w_wait_hold = 1'b1;
              w_next      = S_EXEC;
            end
          end
          OP_JMPA: o_pc_sel = PC_JMP;
          OP_BZ:   o_pc_sel = i_zero ? PC_JMP : PC_INC;
          OP_HALT: w_next   = S_HALT;
          default: o_pc_sel = PC_INC;
        endcase
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
      r_retired  <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_hold ? r_wait_cnt + WCW'(1) : '0;
      if (w_commit) r_retired <= r_retired + RET_W'(1);
    end
  end

  assign o_reg_we    = w_commit & ~(i_opcode[3] | i_opcode[2] | i_opcode[1]);
  assign o_acc_store = w_commit & i_opcode[3];
  assign o_op1_sel   = i_opcode[2] ^ i_opcode[3];
  assign o_alu_op    = i_opcode[1:0];
  assign o_imm_sel   = ~(i_opcode[1] | i_opcode[0]);
  assign o_wdata_sel = o_imm_sel;
  assign o_state     = r_state;
  assign o_retired   = r_retired;

endmodule

// File: tb/tb_control_mc.sv
// Bench for control_mc: directed vector table, hand-written multi-cycle sequences, random run against a reference model.
module tb_control_mc;

  localparam int NSW = 6;
  localparam int TMO = 6;
  localparam int RW  = 4;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic [3:0]    i_opcode = '0;
  logic [2:0]    i_sw_idx = '0;
  logic [NSW-1:0] i_sw = '0;
  logic          i_zero = 1'b0;
  logic          i_mem_rdy = 1'b0;
  logic          o_mem_req, o_reg_we, o_wdata_sel, o_acc_store, o_op1_sel, o_imm_sel, o_timeout;
  logic [1:0]    o_alu_op, o_pc_sel;
  logic [2:0]    o_state;
  logic [RW-1:0] o_retired;

  always #5 clk = ~clk;

  control_mc #(.NUM_SW(NSW), .WAIT_TIMEOUT(TMO), .MEM_HANDSHAKE(1), .RET_W(RW)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_opcode(i_opcode), .i_sw_idx(i_sw_idx), .i_sw(i_sw),
    .i_zero(i_zero), .i_mem_rdy(i_mem_rdy), .o_mem_req(o_mem_req), .o_reg_we(o_reg_we),
    .o_wdata_sel(o_wdata_sel), .o_acc_store(o_acc_store), .o_op1_sel(o_op1_sel),
    .o_imm_sel(o_imm_sel), .o_alu_op(o_alu_op), .o_pc_sel(o_pc_sel), .o_state(o_state),
    .o_timeout(o_timeout), .o_retired(o_retired)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: which phase the instruction is in, how long a WAIT has waited, instructions done.
  int m_st = 0;
  int m_wc = 0;
  int m_ret = 0;

  int obs_st, obs_pc, obs_mr, obs_we, obs_acc, obs_tmo, obs_ret;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic cycle(input logic [3:0] op, input logic [2:0] idx, input logic [5:0] sw,
                       input logic zero, input logic rdy, input logic rst);
    int e_pc, e_mr, e_we, e_acc, e_tmo, n_st, n_wc, sel, opi;
    bit leave, sat;
    logic [7:0] swx;
    @(negedge clk);
    i_opcode = op; i_sw_idx = idx; i_sw = sw; i_zero = zero; i_mem_rdy = rdy; i_reset = rst;
    #1;
    obs_st = int'(o_state); obs_pc = int'(o_pc_sel); obs_mr = int'(o_mem_req);
    obs_we = int'(o_reg_we); obs_acc = int'(o_acc_store); obs_tmo = int'(o_timeout);
    obs_ret = int'(o_retired);
    opi = int'(op);
    swx = {2'b00, sw};
    sel = int'(swx[idx]);
    e_pc = 0; e_mr = 0; e_tmo = 0; leave = 0; n_st = m_st; n_wc = 0;
    if (m_st == 0) begin
      e_mr = 1;
      if (rdy) n_st = 1;
    end else if (m_st == 1) begin
      n_st = 2;
    end else if (m_st == 2) begin
      if (opi == 4 || opi == 5) begin
        sat = (opi == 4) ? (sel == 1) : (sel == 0);
        if (sat) begin
          leave = 1; e_pc = 1;
        end else if (m_wc == TMO - 1) begin
          leave = 1; e_pc = 1; e_tmo = 1;
        end else begin
          n_wc = m_wc + 1;
        end
      end else begin
        leave = 1;
        if (opi == 6) e_pc = 2;
        else if (opi == 7) e_pc = zero ? 2 : 1;
        else if (opi == 3) e_pc = 0;
        else e_pc = 1;
      end
      if (leave) n_st = (opi == 3) ? 3 : 0;
    end
    e_we  = (leave && opi < 2) ? 1 : 0;
    e_acc = (leave && opi >= 8) ? 1 : 0;
    check("state", o_state, m_st);
    check("strobes", {26'd0, o_mem_req, o_reg_we, o_acc_store, o_pc_sel, o_timeout},
          (e_mr * 32) + (e_we * 16) + (e_acc * 8) + (e_pc * 2) + e_tmo);
    check("decode", {28'd0, o_alu_op, o_op1_sel, o_imm_sel ^ 1'b0} | {31'd0, o_wdata_sel} << 0 ? {27'd0, o_alu_op, o_op1_sel, o_imm_sel, o_wdata_sel} : 32'd0,
          ((opi % 4) * 8) + ((((opi / 4) % 2) ^ ((opi / 8) % 2)) * 4) + (((opi % 4) == 0) ? 3 : 0));
    check("retired", o_retired, m_ret);
    if (rst) begin
      m_st = 0; m_wc = 0; m_ret = 0;
    end else begin
      m_st = n_st; m_wc = n_wc;
      if (leave) m_ret = (m_ret + 1) % (1 << RW);
    end
  endtask

  task automatic do_reset();
    cycle(4'd0, 3'd0, 6'd0, 1'b0, 1'b1, 1'b1);
  endtask

  typedef struct {
    logic [3:0] op; logic zero; logic [2:0] idx; logic [5:0] sw;
    int st; int pc; int we; int acc; int mr; int tmo; int ret;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] op, input logic zero, input logic [2:0] idx,
                              input logic [5:0] sw, input int st, input int pc, input int we,
                              input int acc, input int mr, input int tmo, input int ret);
    vec_t v;
    v.op = op; v.zero = zero; v.idx = idx; v.sw = sw; v.st = st; v.pc = pc;
    v.we = we; v.acc = acc; v.mr = mr; v.tmo = tmo; v.ret = ret;
    return v;
  endfunction

  vec_t vt[19];

  initial begin
    int cnt, bad, r0, n_exec, n_tmo, tmo_at, k;
    bit done;
    logic [3:0] rop;

    vt[0]  = mk(4'd0, 0, 0, 0,      0, 0, 0, 0, 1, 0, 0);
    vt[1]  = mk(4'd0, 0, 0, 0,      1, 0, 0, 0, 0, 0, 0);
    vt[2]  = mk(4'd0, 0, 0, 0,      2, 1, 1, 0, 0, 0, 0);
    vt[3]  = mk(4'd7, 1, 0, 0,      0, 0, 0, 0, 1, 0, 1);
    vt[4]  = mk(4'd7, 1, 0, 0,      1, 0, 0, 0, 0, 0, 1);
    vt[5]  = mk(4'd7, 1, 0, 0,      2, 2, 0, 0, 0, 0, 1);
    vt[6]  = mk(4'd7, 0, 0, 0,      0, 0, 0, 0, 1, 0, 2);
    vt[7]  = mk(4'd7, 0, 0, 0,      1, 0, 0, 0, 0, 0, 2);
    vt[8]  = mk(4'd7, 0, 0, 0,      2, 1, 0, 0, 0, 0, 2);
    vt[9]  = mk(4'd6, 0, 0, 0,      0, 0, 0, 0, 1, 0, 3);
    vt[10] = mk(4'd6, 0, 0, 0,      1, 0, 0, 0, 0, 0, 3);
    vt[11] = mk(4'd6, 0, 0, 0,      2, 2, 0, 0, 0, 0, 3);
    vt[12] = mk(4'd8, 0, 0, 0,      0, 0, 0, 0, 1, 0, 4);
    vt[13] = mk(4'd8, 0, 0, 0,      1, 0, 0, 0, 0, 0, 4);
    vt[14] = mk(4'd8, 0, 0, 0,      2, 1, 0, 1, 0, 0, 4);
    vt[15] = mk(4'd5, 0, 7, 6'h3F,  0, 0, 0, 0, 1, 0, 5);
    vt[16] = mk(4'd5, 0, 7, 6'h3F,  1, 0, 0, 0, 0, 0, 5);
    vt[17] = mk(4'd5, 0, 7, 6'h3F,  2, 1, 0, 0, 0, 0, 5);
    vt[18] = mk(4'd0, 0, 0, 0,      0, 0, 0, 0, 1, 0, 6);

    i_reset = 1'b1;
    repeat (2) @(posedge clk);
    m_st = 0; m_wc = 0; m_ret = 0;

    // Directed table: ADD, BZ taken/not taken, JMPA, accumulator op, out-of-range WAIT1 index.
    for (int i = 0; i < 19; i++) begin
      cycle(vt[i].op, vt[i].idx, vt[i].sw, vt[i].zero, 1'b1, 1'b0);
      check($sformatf("vec%0d", i),
            (obs_st << 12) | (obs_pc << 8) | (obs_we << 6) | (obs_acc << 4) | (obs_mr << 2) | obs_tmo | (obs_ret << 16),
            (vt[i].st << 12) | (vt[i].pc << 8) | (vt[i].we << 6) | (vt[i].acc << 4) | (vt[i].mr << 2) | vt[i].tmo | (vt[i].ret << 16));
    end

    // MemRdy low for 4 Fetch cycles.
    do_reset();
    cnt = 0; bad = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(4'd0, 3'd0, 6'd0, 1'b0, (i == 4) ? 1'b1 : 1'b0, 1'b0);
      cnt += obs_mr;
      if (obs_pc != 0) bad++;
    end
    check("memreq_cycles", cnt, 5);
    check("fetch_pcsel", bad, 0);
    cycle(4'd0, 3'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    check("fetch_to_read", obs_st, 1);

    // WAIT0 on switch 5 rising after 3 Execute cycles.
    do_reset();
    cycle(4'd4, 3'd5, 6'd0, 1'b0, 1'b1, 1'b0);
    cycle(4'd4, 3'd5, 6'd0, 1'b0, 1'b1, 1'b0);
    cnt = 0; n_tmo = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(4'd4, 3'd5, 6'd0, 1'b0, 1'b1, 1'b0);
      if (obs_st == 2 && obs_pc == 0) cnt++;
      n_tmo += obs_tmo;
    end
    r0 = obs_ret;
    cycle(4'd4, 3'd5, 6'b100000, 1'b0, 1'b1, 1'b0);
    n_tmo += obs_tmo;
    check("wait0_release_pc", obs_pc, 1);
    cycle(4'd0, 3'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    check("wait0_hold_cycles", cnt, 3);
    check("wait0_no_timeout", n_tmo, 0);
    check("wait0_retired", obs_ret, (r0 + 1) % (1 << RW));

    // WAIT1 on a switch held high: forced out by the timeout.
    do_reset();
    cycle(4'd5, 3'd2, 6'b000100, 1'b0, 1'b1, 1'b0);
    cycle(4'd5, 3'd2, 6'b000100, 1'b0, 1'b1, 1'b0);
    n_exec = 0; n_tmo = 0; tmo_at = -1; done = 0;
    for (k = 0; k < 12 && !done; k++) begin
      cycle(4'd5, 3'd2, 6'b000100, 1'b0, 1'b1, 1'b0);
      if (obs_st != 2) done = 1;
      else begin
        n_exec++;
        if (obs_tmo) begin n_tmo++; tmo_at = n_exec; end
      end
    end
    check("wait1_exec_cycles", n_exec, TMO);
    check("wait1_timeout_pulses", n_tmo, 1);
    check("wait1_timeout_cycle", tmo_at, TMO);

    // HALT, then Halted held 20 cycles, then reset out of it.
    do_reset();
    cycle(4'd3, 3'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    cycle(4'd3, 3'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    cycle(4'd3, 3'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    check("halt_commit_pc", obs_pc, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(4'($urandom_range(0, 15)), 3'd0, 6'($urandom), 1'($urandom), 1'b1, 1'b0);
      if (obs_st != 3 || obs_mr || obs_we || obs_acc || obs_pc != 0 || obs_tmo) bad++;
    end
    check("halted_quiet", bad, 0);
    check("halted_retired", obs_ret, 1);
    do_reset();
    cycle(4'd0, 3'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    check("halt_reset_state", obs_st, 0);
    check("halt_reset_retired", obs_ret, 0);

    // Reset mid-WAIT after one retired ADD.
    for (int i = 0; i < 3; i++) cycle(4'd0, 3'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(4'd4, 3'd5, 6'd0, 1'b0, 1'b1, 1'b0);
    check("midwait_state", obs_st, 2);
    check("midwait_retired", obs_ret, 1);
    cycle(4'd4, 3'd5, 6'd0, 1'b0, 1'b1, 1'b1);
    cycle(4'd0, 3'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    check("midwait_reset_state", obs_st, 0);
    check("midwait_reset_retired", obs_ret, 0);

    // Random run against the model.
    for (int i = 0; i < 4000; i++) begin
      rop = 4'($urandom_range(0, 15));
      cycle(rop, 3'($urandom_range(0, 7)), 6'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
